// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and its hazard/sequencing controller.
// Purely wires: no latency of its own.
// No backpressure here; the controller's stall/freeze outputs are the flow control.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Sequencing requests
    logic             start_i;
    logic             halt_i;
    // Hazard sources seen in ID and EX
    logic             idex_memread_i;
    logic [4:0]       idex_rt_i;
    logic [4:0]       ifid_rs_i;
    logic [4:0]       ifid_rt_i;
    logic             ifid_uses_rt_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             mem_wait_i;
    // Pipeline register controls
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             freeze_o;
    logic             running_o;
    logic             halted_o;
    // Performance counters
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] wait_cnt_o;

    // Datapath side: drives hazard sources, consumes controls
    modport master (
        output start_i, halt_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               ifid_uses_rt_i, branch_taken_i, jump_i, mem_wait_i,
        input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o,
               running_o, halted_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );

    // Controller side
    modport slave (
        input  start_i, halt_i, idex_memread_i, idex_rt_i, ifid_rs_i, ifid_rt_i,
               ifid_uses_rt_i, branch_taken_i, jump_i, mem_wait_i,
        output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, freeze_o,
               running_o, halted_o, cycle_cnt_o, stall_cnt_o, flush_cnt_o, wait_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline controller: start/halt sequencing, load-use stall, ID branch flush, counters.
// Control outputs are combinational (0 cycles) from hazard inputs; state/counters update at the edge.
// mem_wait freezes the whole pipe; load-use holds PC/IF-ID and bubbles ID/EX; flush waits out a stall.
module pipe_hazard_ctrl #(
    parameter int MAX_CYCLES = 0,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Value of cycle_cnt during the last permitted RUN cycle (unused when the limit is off)
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;

    logic load_use;
    logic limit_hit;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, freeze;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    // Load in EX whose destination feeds the instruction in ID; $0 never conflicts
    always_comb begin
        load_use = bus.idex_memread_i && (bus.idex_rt_i != 5'd0) &&
                   ((bus.idex_rt_i == bus.ifid_rs_i) ||
                    (bus.ifid_uses_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));
        limit_hit = (MAX_CYCLES != 0) && (cycle_cnt_q == LIMIT_M1);
    end

    // Next state and pipeline controls; outside RUN the pipe is held with a bubble in ID/EX
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        freeze      = 1'b1;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.mem_wait_i) begin
                    // Everything holds; hazards are re-evaluated once memory is ready
                    idex_bubble = 1'b0;
                end else if (load_use) begin
                    // Branch resolution in ID is stale until the load data arrives
                    freeze = 1'b0;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_bubble = 1'b0;
                    freeze      = 1'b0;
                    ifid_flush  = bus.branch_taken_i || bus.jump_i;
                end
                if (bus.halt_i || limit_hit) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating performance counters, advanced only for RUN cycles
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (state_q == RUN) begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            if (bus.mem_wait_i) begin
                wait_cnt_d = sat_inc(wait_cnt_q);
            end else if (load_use) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (ifid_flush) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end
        end
    end

    // State and counter registers; reset wins over every other event at the edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.pc_write_o    = pc_write;
    assign bus.ifid_write_o  = ifid_write;
    assign bus.ifid_flush_o  = ifid_flush;
    assign bus.idex_bubble_o = idex_bubble;
    assign bus.freeze_o      = freeze;
    assign bus.running_o     = (state_q == RUN);
    assign bus.halted_o      = (state_q == HALT);
    assign bus.cycle_cnt_o   = cycle_cnt_q;
    assign bus.stall_cnt_o   = stall_cnt_q;
    assign bus.flush_cnt_o   = flush_cnt_q;
    assign bus.wait_cnt_o    = wait_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the 5-stage CPU: it sequences start-up and halt, and detects load-use hazards and taken branches/jumps resolved in ID. It drives the PC, IF/ID and ID/EX stall/flush/bubble controls and a global freeze for data-memory wait states. It also keeps saturating performance counters (cycles, stalls, flushes, memory waits) that the testbench reads to report pipeline behaviour.

## Interface
- MAX_CYCLES, 0, RUN cycles before automatic halt; 0 disables the limit
- CNT_W, 32, width of every performance counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset: synchronous, active-high
- start_i  in  1  begin execution; sampled only in IDLE
- halt_i  in  1  request halt (e.g. decoded halt instruction in ID)
- idex_memread_i  in  1  instruction in EX is a load
- idex_rt_i  in  5  destination register of the load in EX
- ifid_rs_i  in  5  rs of the instruction in ID
- ifid_rt_i  in  5  rt of the instruction in ID
- ifid_uses_rt_i  in  1  instruction in ID reads rt as a source
- branch_taken_i  in  1  branch in ID resolved taken
- jump_i  in  1  jump in ID
- mem_wait_i  in  1  data memory not ready this cycle
- pc_write_o  out  1  PC register load enable
- ifid_write_o  out  1  IF/ID register load enable
- ifid_flush_o  out  1  IF/ID loads a NOP
- idex_bubble_o  out  1  ID/EX control fields forced to zero
- freeze_o  out  1  every pipeline register, including PC, holds
- running_o  out  1  state == RUN
- halted_o  out  1  state == HALT
- cycle_cnt_o, stall_cnt_o, flush_cnt_o, wait_cnt_o  out  CNT_W each  performance counters

## Operation
- FSM states: IDLE, RUN, HALT. Reset → IDLE.
- IDLE → RUN when start_i=1 at a rising edge. RUN → HALT when halt_i=1, or when MAX_CYCLES≠0 and cycle_cnt_o = MAX_CYCLES−1, at the edge. HALT is absorbing until rst_i.
- IDLE and HALT: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1, freeze_o=1.
- RUN: control outputs are combinational on the current inputs, evaluated in this priority:
  - mem_wait_i=1 → freeze_o=1, pc_write_o=0, ifid_write_o=0, idex_bubble_o=0, ifid_flush_o=0. No hazard is evaluated.
  - load-use: idex_memread_i=1, idex_rt_i≠0, and (idex_rt_i==ifid_rs_i or (ifid_uses_rt_i and idex_rt_i==ifid_rt_i)) → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. ifid_flush_o is suppressed even if branch/jump is asserted; the branch is re-evaluated next cycle.
  - otherwise branch_taken_i or jump_i → ifid_flush_o=1, pc_write_o=1, ifid_write_o=1.
  - otherwise all enables = 1, bubble/flush/freeze = 0.
- Register 0 never creates a hazard.
- Counters are zeroed on reset and hold in IDLE/HALT. In RUN: cycle_cnt increments every cycle; wait_cnt on mem_wait cycles; stall_cnt on load-use stall cycles; flush_cnt on cycles with ifid_flush_o=1.
- All counters saturate at 2^CNT_W−1; there is no wrap.

## Timing
- Reset values: state IDLE, all counters 0, running_o=0, halted_o=0, pc_write_o=0, freeze_o=1, idex_bubble_o=1.
- start_i sampled high at edge k → running_o=1 and pc_write_o=1 in the cycle after edge k. The first PC advance happens at edge k+1.
- Control outputs have zero latency from the hazard inputs. Counters update at the edge that closes the cycle being counted.
- halt_i at edge k → halted_o=1 after edge k. The cycle ending at edge k is counted in cycle_cnt.
- rst_i has priority over every event at the same edge, including a mid-RUN reset: state and counters clear at that edge.
- halt_i together with mem_wait_i → HALT is still taken. Start_i outside IDLE is ignored.

## Test plan
- Reset, then start_i pulse, 10 free cycles → running_o=1, pc_write_o=1, cycle_cnt_o=10, stall/flush/wait=0.
- Load into $8 in EX, ID reads rs=$8 → one cycle of pc_write_o=0, idex_bubble_o=1, stall_cnt_o=1. Repeat with idex_rt_i=0 → no stall.
- Branch taken together with a load-use hazard → cycle 1: stall, no flush. Cycle 2 (hazard gone): ifid_flush_o=1. Result stall_cnt=1, flush_cnt=1.
- mem_wait_i for 3 cycles during a load-use condition → freeze_o=1 for 3 cycles, wait_cnt=3, stall_cnt unchanged.
- MAX_CYCLES=8, start → halted_o=1 after 8 RUN cycles, cycle_cnt_o=8, outputs frozen thereafter; rst_i then start → counters restart from 0.
- CNT_W=3, run 12 cycles → cycle_cnt_o=7 (saturated).
